// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared types and constants for the PC redirect unit.
// Optional build macro used by this slice: PC_REDIRECT_STATS_EN (redirect statistics counters).
package pc_redirect_unit_pkg;

  // Redirect FSM states: normal fetch, post-redirect squash window, terminal halt
  typedef enum logic [1:0] {
    PCR_RUN   = 2'd0,
    PCR_FLUSH = 2'd1,
    PCR_HALT  = 2'd2
  } pcr_state_t;

  localparam logic ONE  = 1'b1;
  localparam logic ZERO = 1'b0;

  // Default PC after reset
  localparam logic [31:0] PCR_RESET_VECTOR = 32'h0000_0000;

  // Instructions are word aligned, so both low PC bits must be clear
  localparam logic [1:0] PCR_ALIGN_MASK = 2'b11;

  // True when the two low target bits break instruction alignment
  function automatic logic pcr_misaligned(input logic [1:0] lsbs);
    return |(lsbs & PCR_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: EX-stage decision inputs and fetch-PC outputs of the redirect unit.
// Optional build macro: PC_REDIRECT_STATS_EN adds the redirect statistics counters.
interface pc_redirect_unit_if #(
  parameter int XLEN = 32
);

  logic            stall_i;
  logic            branch_i;
  logic            jal_i;
  logic            jalr_i;
  logic            halt_i;
  logic [XLEN-1:0] ex_pc_i;
  logic [XLEN-1:0] ex_imm_i;
  logic [XLEN-1:0] ex_rs1_i;

  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus4_o;
  logic            flush_o;
  logic            halted_o;
  logic            misaligned_o;

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0]     redirect_cnt_o;
  logic [31:0]     taken_branch_cnt_o;

  // Pipeline side: drives EX decisions, observes the fetch PC
  modport master (
    output stall_i, branch_i, jal_i, jalr_i, halt_i, ex_pc_i, ex_imm_i, ex_rs1_i,
    input  pc_o, pc_plus4_o, flush_o, halted_o, misaligned_o,
    input  redirect_cnt_o, taken_branch_cnt_o
  );

  // Redirect unit side
  modport slave (
    input  stall_i, branch_i, jal_i, jalr_i, halt_i, ex_pc_i, ex_imm_i, ex_rs1_i,
    output pc_o, pc_plus4_o, flush_o, halted_o, misaligned_o,
    output redirect_cnt_o, taken_branch_cnt_o
  );
`else
  // Pipeline side: drives EX decisions, observes the fetch PC
  modport master (
    output stall_i, branch_i, jal_i, jalr_i, halt_i, ex_pc_i, ex_imm_i, ex_rs1_i,
    input  pc_o, pc_plus4_o, flush_o, halted_o, misaligned_o
  );

  // Redirect unit side
  modport slave (
    input  stall_i, branch_i, jal_i, jalr_i, halt_i, ex_pc_i, ex_imm_i, ex_rs1_i,
    output pc_o, pc_plus4_o, flush_o, halted_o, misaligned_o
  );
`endif

endinterface

// File: rtl/pc_redirect_unit_target_calc.sv
// pc_target_calc: combinational redirect target for branches/JAL (pc+imm) and
// JALR ((rs1+imm) with bit 0 cleared), plus the misalignment flag on the chosen target.
// Additions wrap modulo 2^XLEN; overflow is not reported.
module pc_target_calc
  import pc_redirect_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            jalr_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  output logic [XLEN-1:0] tgt_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;

  assign br_tgt       = ex_pc_i + ex_imm_i;
  assign jalr_sum     = ex_rs1_i + ex_imm_i;
  assign jalr_tgt     = jalr_sum & ~XLEN'(1);
  assign tgt_o        = jalr_i ? jalr_tgt : br_tgt;
  assign misaligned_o = pcr_misaligned(tgt_o[1:0]);

endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC, applies EX-stage redirects, drives a timed
// flush of younger stages, honours load-use stalls and enters a terminal halt.
// Optional build macro: PC_REDIRECT_STATS_EN adds saturating redirect counters.
// FLUSH_CYCLES must lie in 1..3 (the flush counter is 2 bits wide).
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PCR_RESET_VECTOR),
  parameter int              FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  pc_redirect_unit_if.slave bus
);

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  pcr_state_t      state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [1:0]      flush_cnt;
  logic            flush_q;
  logic            halted_q;
  logic            misaligned_q;

  logic [XLEN-1:0] tgt;
  logic            tgt_misaligned;
  logic            ex_valid;
  logic            redirect;

  pc_target_calc #(
    .XLEN (XLEN)
  ) u_target_calc (
    .jalr_i       (bus.jalr_i),
    .ex_pc_i      (bus.ex_pc_i),
    .ex_imm_i     (bus.ex_imm_i),
    .ex_rs1_i     (bus.ex_rs1_i),
    .tgt_o        (tgt),
    .misaligned_o (tgt_misaligned)
  );

  // During FLUSH the EX instruction is one we are squashing, so it cannot redirect
  assign ex_valid = (state == PCR_RUN);
  assign redirect = (bus.branch_i | bus.jal_i | bus.jalr_i) & ex_valid;
  assign pc_plus4 = pc_q + XLEN'(4);

  // FSM with PC register, flush countdown and sticky halt/misalign flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PCR_RUN;
      pc_q         <= RESET_VECTOR;
      flush_cnt    <= 2'd0;
      flush_q      <= ZERO;
      halted_q     <= ZERO;
      misaligned_q <= ZERO;
    end else begin
      case (state)
        PCR_RUN: begin
          if (bus.halt_i) begin
            state    <= PCR_HALT;
            halted_q <= ONE;
          end else if (redirect && tgt_misaligned) begin
            state        <= PCR_HALT;
            halted_q     <= ONE;
            misaligned_q <= ONE;
          end else if (redirect) begin
            pc_q      <= tgt;
            flush_q   <= ONE;
            flush_cnt <= FLUSH_INIT;
            state     <= PCR_FLUSH;
          end else if (!bus.stall_i) begin
            pc_q <= pc_plus4;
          end
        end
        PCR_FLUSH: begin
          if (!bus.stall_i) begin
            pc_q <= pc_plus4;
          end
          if (flush_cnt == 2'd0) begin
            state   <= PCR_RUN;
            flush_q <= ZERO;
          end else begin
            flush_cnt <= flush_cnt - 2'd1;
          end
        end
        PCR_HALT: begin
          flush_q <= ZERO;
        end
        default: begin
          state   <= PCR_RUN;
          flush_q <= ZERO;
        end
      endcase
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.pc_plus4_o   = pc_plus4;
  assign bus.flush_o      = flush_q;
  assign bus.halted_o     = halted_q;
  assign bus.misaligned_o = misaligned_q;

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] redirect_cnt;
  logic [31:0] taken_branch_cnt;
  logic        accepted;
  logic        accepted_branch;

  // A redirect only counts when it actually moves the PC (no halt, no misalignment)
  assign accepted        = redirect & ~bus.halt_i & ~tgt_misaligned;
  assign accepted_branch = accepted & bus.branch_i & ~bus.jal_i & ~bus.jalr_i;

  // Saturating counters of accepted redirects and of plain taken branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt     <= 32'd0;
      taken_branch_cnt <= 32'd0;
    end else begin
      if (accepted && (redirect_cnt != 32'hFFFF_FFFF)) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
      if (accepted_branch && (taken_branch_cnt != 32'hFFFF_FFFF)) begin
        taken_branch_cnt <= taken_branch_cnt + 32'd1;
      end
    end
  end

  assign bus.redirect_cnt_o     = redirect_cnt;
  assign bus.taken_branch_cnt_o = taken_branch_cnt;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed vectors for pc_redirect_unit. Each stimulus pushes the
// outputs expected after the next rising edge; a monitor pops and compares them.
// Build with PC_REDIRECT_STATS_EN defined to also exercise the statistics counters.
module tb_pc_redirect_unit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pc_redirect_unit_if #(.XLEN(32)) bus_if ();

  pc_redirect_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // control word {stall, branch, jal, jalr, halt}
  localparam logic [4:0] C_IDLE   = 5'b00000;
  localparam logic [4:0] C_STALL  = 5'b10000;
  localparam logic [4:0] C_BRANCH = 5'b01000;
  localparam logic [4:0] C_JAL    = 5'b00100;
  localparam logic [4:0] C_JALR   = 5'b00010;
  localparam logic [4:0] C_HALT   = 5'b00001;

  // expected flags {flush, halted, misaligned}
  localparam logic [2:0] F_NONE  = 3'b000;
  localparam logic [2:0] F_FLUSH = 3'b100;
  localparam logic [2:0] F_HALT  = 3'b010;
  localparam logic [2:0] F_MIS   = 3'b011;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        flush;
    logic        halted;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input exp_t e);
    checks++;
    if (bus_if.pc_o !== e.pc || bus_if.pc_plus4_o !== (e.pc + 32'd4) ||
        bus_if.flush_o !== e.flush || bus_if.halted_o !== e.halted ||
        bus_if.misaligned_o !== e.mis) begin
      errors++;
      $display("[TB] FAIL %s: got pc=%h pc4=%h flush=%b halted=%b mis=%b, want pc=%h pc4=%h flush=%b halted=%b mis=%b",
               e.name, bus_if.pc_o, bus_if.pc_plus4_o, bus_if.flush_o, bus_if.halted_o,
               bus_if.misaligned_o, e.pc, e.pc + 32'd4, e.flush, e.halted, e.mis);
    end
  endtask

  task automatic checkCount(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // Called at a falling edge: drive inputs, queue the outputs due after the next rising edge
  task automatic applyStimulus(input string nm, input logic [4:0] ctl,
                               input logic [31:0] epc, input logic [31:0] eimm,
                               input logic [31:0] ers1, input logic [31:0] xpc,
                               input logic [2:0] xf);
    exp_t e;
    {bus_if.stall_i, bus_if.branch_i, bus_if.jal_i, bus_if.jalr_i, bus_if.halt_i} = ctl;
    bus_if.ex_pc_i  = epc;
    bus_if.ex_imm_i = eimm;
    bus_if.ex_rs1_i = ers1;
    e.name = nm;
    e.pc   = xpc;
    {e.flush, e.halted, e.mis} = xf;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic clearInputs();
    {bus_if.stall_i, bus_if.branch_i, bus_if.jal_i, bus_if.jalr_i, bus_if.halt_i} = C_IDLE;
    bus_if.ex_pc_i  = 32'h0;
    bus_if.ex_imm_i = 32'h0;
    bus_if.ex_rs1_i = 32'h0;
  endtask

  // Asserts reset mid-cycle (between edges) and releases it on a falling edge
  task automatic doReset(input string nm);
    exp_t e;
    clearInputs();
    @(posedge clk);
    #3;
    e.name = nm;
    e.pc   = 32'h0;
    {e.flush, e.halted, e.mis} = F_NONE;
    sb_q.push_back(e);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare one queued expectation after every rising edge or reset assertion
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, pending=%0d", sb_q.size());
    $fatal(1, "[TB] timeout");
  end

  initial begin
    exp_t r;
    rst_n = 1'b0;
    clearInputs();
    #1;
    r.name = "reset state";
    r.pc   = 32'h0;
    {r.flush, r.halted, r.mis} = F_NONE;
    checkOutput(r);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] free-running fetch");
    applyStimulus("seq pc 4", C_IDLE, 0, 0, 0, 32'h4, F_NONE);
    applyStimulus("seq pc 8", C_IDLE, 0, 0, 0, 32'h8, F_NONE);
    applyStimulus("seq pc C", C_IDLE, 0, 0, 0, 32'hC, F_NONE);

    $display("[TB] branch redirect, branches inside flush ignored");
    applyStimulus("branch tgt",     C_BRANCH, 32'h100, 32'h40, 0, 32'h140, F_FLUSH);
    applyStimulus("flush ignore 1", C_BRANCH, 32'h300, 32'h8,  0, 32'h144, F_FLUSH);
    applyStimulus("flush ignore 2", C_BRANCH, 32'h300, 32'h8,  0, 32'h148, F_NONE);
    applyStimulus("after flush",    C_IDLE,   0, 0, 0, 32'h14C, F_NONE);

    $display("[TB] jalr overriding stall");
    applyStimulus("jalr+stall",  C_STALL | C_JALR, 0, 32'h1, 32'h203, 32'h204, F_FLUSH);
    applyStimulus("flush stall", C_STALL, 0, 0, 0, 32'h204, F_FLUSH);
    applyStimulus("jalr done",   C_IDLE,  0, 0, 0, 32'h208, F_NONE);

    $display("[TB] jal, negative offset wrap, jalr bit0");
    applyStimulus("jal tgt",      C_JAL,    32'h400, 32'h20, 0, 32'h420, F_FLUSH);
    applyStimulus("jal flush",    C_IDLE,   0, 0, 0, 32'h424, F_FLUSH);
    applyStimulus("jal done",     C_IDLE,   0, 0, 0, 32'h428, F_NONE);
    applyStimulus("neg imm tgt",  C_BRANCH, 32'h10, 32'hFFFF_FFF0, 0, 32'h0, F_FLUSH);
    applyStimulus("neg flush",    C_IDLE,   0, 0, 0, 32'h4, F_FLUSH);
    applyStimulus("neg done",     C_IDLE,   0, 0, 0, 32'h8, F_NONE);
    applyStimulus("jalr bit0",    C_JALR,   0, 32'h0, 32'h301, 32'h300, F_FLUSH);
    applyStimulus("jalr0 flush",  C_IDLE,   0, 0, 0, 32'h304, F_FLUSH);
    applyStimulus("jalr0 done",   C_IDLE,   0, 0, 0, 32'h308, F_NONE);
    doReset("reset after redirects");

    $display("[TB] stall hold then halt");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus("count to 0x20", C_IDLE, 0, 0, 0, 32'(i * 4), F_NONE);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall hold", C_STALL, 0, 0, 0, 32'h20, F_NONE);
    end
    applyStimulus("stall release", C_IDLE,   0, 0, 0, 32'h24, F_NONE);
    applyStimulus("halt enter",    C_HALT,   0, 0, 0, 32'h24, F_HALT);
    applyStimulus("halt frozen 1", C_BRANCH, 32'h100, 32'h40, 0, 32'h24, F_HALT);
    applyStimulus("halt frozen 2", C_IDLE,   0, 0, 0, 32'h24, F_HALT);
    doReset("reset mid-halt");

    $display("[TB] halt beats redirect");
    applyStimulus("halt priority", C_HALT | C_BRANCH, 32'h100, 32'h40, 0, 32'h0, F_HALT);
    doReset("reset after halt priority");

    $display("[TB] misaligned branch target");
    applyStimulus("misaligned br", C_BRANCH, 32'h10, 32'h6, 0, 32'h0, F_MIS);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("misaligned sticky", (i % 2 == 0) ? C_BRANCH : C_JAL,
                    32'h100, 32'h40, 0, 32'h0, F_MIS);
    end
    doReset("reset after misaligned");

    $display("[TB] misaligned jalr target");
    applyStimulus("misaligned jalr", C_JALR, 0, 32'h0, 32'h102, 32'h0, F_MIS);
    doReset("reset after jalr misaligned");

`ifdef PC_REDIRECT_STATS_EN
    $display("[TB] statistics counters");
    checkCount("redirect_cnt reset", bus_if.redirect_cnt_o, 32'd0);
    checkCount("taken_cnt reset",    bus_if.taken_branch_cnt_o, 32'd0);
    applyStimulus("st br1",    C_BRANCH, 32'h100, 32'h40, 0, 32'h140, F_FLUSH);
    applyStimulus("st ignore", C_BRANCH, 32'h500, 32'h4,  0, 32'h144, F_FLUSH);
    applyStimulus("st idle1",  C_IDLE,   0, 0, 0, 32'h148, F_NONE);
    applyStimulus("st br2",    C_BRANCH, 32'h200, 32'h8,  0, 32'h208, F_FLUSH);
    applyStimulus("st idle2",  C_IDLE,   0, 0, 0, 32'h20C, F_FLUSH);
    applyStimulus("st idle3",  C_IDLE,   0, 0, 0, 32'h210, F_NONE);
    applyStimulus("st br3",    C_BRANCH, 32'h210, 32'h10, 0, 32'h220, F_FLUSH);
    applyStimulus("st idle4",  C_IDLE,   0, 0, 0, 32'h224, F_FLUSH);
    applyStimulus("st idle5",  C_IDLE,   0, 0, 0, 32'h228, F_NONE);
    applyStimulus("st jal",    C_JAL,    32'h300, 32'h100, 0, 32'h400, F_FLUSH);
    applyStimulus("st idle6",  C_IDLE,   0, 0, 0, 32'h404, F_FLUSH);
    applyStimulus("st idle7",  C_IDLE,   0, 0, 0, 32'h408, F_NONE);
    applyStimulus("st misal",  C_BRANCH, 32'h0, 32'h2, 0, 32'h408, F_MIS);
    checkCount("redirect_cnt", bus_if.redirect_cnt_o, 32'd4);
    checkCount("taken_cnt",    bus_if.taken_branch_cnt_o, 32'd3);
    doReset("reset after stats");
    checkCount("redirect_cnt cleared", bus_if.redirect_cnt_o, 32'd0);
`endif

    clearInputs();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the program counter and sits directly downstream of the branching unit.
- Consumes the final `branch` decision plus jump indications from EX, computes the redirect target, updates the PC, and drives a timed flush of younger pipeline registers.
- Handles load-use stalls from the hazard unit and a terminal halt (ECALL/EBREAK/FENCE) state.

Parameters:
- XLEN, 32, datapath/PC width
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect (IF/ID + ID/EX); legal range 1..3

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hazard-unit stall; hold PC
- branch_i  in  1  final decision from branching unit (EX stage)
- jal_i  in  1  EX instruction is JAL
- jalr_i  in  1  EX instruction is JALR
- halt_i  in  1  EX instruction is ECALL/EBREAK/FENCE
- ex_pc_i  in  XLEN  PC of the EX instruction
- ex_imm_i  in  XLEN  sign-extended immediate of the EX instruction
- ex_rs1_i  in  XLEN  forwarded rs1 value of the EX instruction
- pc_o  out  XLEN  current fetch PC
- pc_plus4_o  out  XLEN  pc_o + 4, combinational
- flush_o  out  1  squash younger pipeline registers
- halted_o  out  1  core halted
- misaligned_o  out  1  sticky: halted due to misaligned target

Behaviour:
- Reset (async, rst_n=0):
  - pc_o=RESET_VECTOR, flush_o=0, halted_o=0, misaligned_o=0.
  - State=RUN, flush counter=0.
  - Reset mid-flush or mid-halt returns to RUN immediately.
- Target computation (combinational, XLEN-bit, wraps modulo 2^XLEN, no overflow detection):
  - br_tgt = ex_pc_i + ex_imm_i
  - jalr_tgt = (ex_rs1_i + ex_imm_i) & ~1
  - redirect = (branch_i | jal_i | jalr_i) & EX instruction valid
  - tgt = jalr_tgt if jalr_i, else br_tgt
- EX-valid qualification: an EX instruction is treated as valid only when state=RUN. While in FLUSH, all of branch_i/jal_i/jalr_i/halt_i are ignored because they belong to squashed instructions.
- FSM states: RUN, FLUSH, HALT.
- RUN, priority high to low:
  1. halt_i: PC holds; next state HALT; halted_o=1 the next cycle.
  2. redirect with tgt[1:0]!=0: PC holds; next state HALT; misaligned_o=1 and halted_o=1 the next cycle.
  3. redirect: pc_o<=tgt; flush_o<=1; counter<=FLUSH_CYCLES-1; next state FLUSH.
  4. stall_i: PC holds.
  5. Otherwise: pc_o<=pc_o+4.
  - A redirect overrides stall_i in the same cycle; the stalled instruction is younger and gets flushed.
- FLUSH:
  - flush_o=1 every cycle in this state.
  - pc_o advances by 4 unless stall_i is high.
  - Counter decrements each cycle; at 0, next state RUN and flush_o=0 the following cycle.
  - Total flush_o high time after a redirect is exactly FLUSH_CYCLES cycles, starting the cycle after the redirect edge.
- HALT: pc_o frozen; flush_o=0; exits only via reset. halted_o and misaligned_o are registered and sticky.
- Latency: redirect decision to new pc_o is 1 clock edge.

Optional Feature:
- Macro: PC_REDIRECT_STATS_EN
- When defined, adds outputs:
  - redirect_cnt_o (32 bits): counts accepted redirects.
  - taken_branch_cnt_o (32 bits): counts accepted redirects with branch_i=1 and no jump.
- Both counters reset to 0, saturate at 32'hFFFF_FFFF, and do not increment for ignored (FLUSH-state) or misaligned redirects.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package/defines include file:
  - FSM state encodings PCR_RUN/PCR_FLUSH/PCR_HALT (2 bits).
  - `ONE`/`ZERO` constants.
  - RESET_VECTOR default.
  - Instruction alignment mask.
- One natural sub-module: pc_target_calc (pure combinational: br_tgt, jalr_tgt, tgt select, misalign flag). The FSM, PC register and counters remain in the top.

Test Plan:
- Reset release, no stimulus, 4 cycles -> pc_o = 0x0, 0x4, 0x8, 0xC; flush_o=0 throughout.
- ex_pc_i=0x100, ex_imm_i=0x40, branch_i=1 for one cycle -> next pc_o=0x140; flush_o high exactly 2 cycles; a branch_i=1 injected during the flush is ignored.
- jalr_i=1, ex_rs1_i=0x203, ex_imm_i=0x1 -> pc_o=0x204 (bit0 cleared); same cycle with stall_i=1 -> redirect still taken.
- branch_i=1, ex_pc_i=0x10, ex_imm_i=0x6 -> target 0x16 is misaligned -> pc_o holds; misaligned_o=1 and halted_o=1 the next cycle; stays halted for 10 cycles.
- stall_i=1 for 3 cycles at pc_o=0x20 -> pc_o stays 0x20, then 0x24 once stall_i drops; halt_i pulse -> halted_o=1, PC frozen; rst_n=0 mid-halt -> all outputs back to reset values asynchronously.
- With PC_REDIRECT_STATS_EN: 3 branches + 1 JAL accepted, 1 ignored in FLUSH -> redirect_cnt_o=4, taken_branch_cnt_o=3.
